// File: rtl/time_entry_if.sv
// Keypad-to-timer-digit bundle for the time_entry block.
// The slave side is the entry block; the master side drives the keypad and busy.
interface time_entry_if;
   logic [9:0] key;
   logic       clr_key;
   logic       start_key;
   logic       busy;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] minutes;
   logic       loadn;
   logic [1:0] count;
   logic       err;

   modport slave (
      input  key, clr_key, start_key, busy,
      output sec_ones, sec_tens, minutes, loadn, count, err
   );

   modport master (
      output key, clr_key, start_key, busy,
      input  sec_ones, sec_tens, minutes, loadn, count, err
   );
endinterface

// File: rtl/time_entry.sv
// Keypad time entry: shifts BCD digits in, validates, strobes them into the timer digits.
// Optional macro TIME_ENTRY_SYNC_EN adds a two-flop input synchronizer ahead of edge detection.
module time_entry #(
   parameter int MAX_SEC_TENS = 5
) (
   input logic         clk,
   input logic         clrn,
   time_entry_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

   localparam logic [3:0] MAX_TENS = 4'(MAX_SEC_TENS);

   state_t      state_reg;
   logic [3:0]  sec_ones_reg, sec_tens_reg, minutes_reg;
   logic [1:0]  count_reg;
   logic        loadn_reg, err_reg;

   logic [11:0] raw, cur, prev_reg;
   logic        cur_valid, armed_reg;
   logic        press, multi, single;
   logic [3:0]  digit;

   // bit 11 = start, bit 10 = clear, bits 9:0 = digit keys
   assign raw = {bus.start_key, bus.clr_key, bus.key};

`ifdef TIME_ENTRY_SYNC_EN
   logic [11:0] sync1_reg, sync2_reg;
   logic        vld1_reg, vld2_reg;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         vld1_reg  <= 1'b0;
         vld2_reg  <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         vld1_reg  <= 1'b1;
         vld2_reg  <= vld1_reg;
      end
   end

   assign cur       = sync2_reg;
   assign cur_valid = vld2_reg;
`else
   assign cur       = raw;
   assign cur_valid = 1'b1;
`endif

   // armed only after a genuine all-zero sample, so keys held through reset never count
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         prev_reg  <= '0;
         armed_reg <= 1'b0;
      end else begin
         prev_reg  <= cur;
         armed_reg <= armed_reg | (cur_valid && (cur == 12'd0));
      end
   end

   assign press  = armed_reg && (prev_reg == 12'd0) && (cur != 12'd0);
   assign multi  = (cur & (cur - 12'd1)) != 12'd0;
   assign single = press && !multi;

   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (cur[i]) digit = 4'(i);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_reg    <= IDLE;
         sec_ones_reg <= 4'd0;
         sec_tens_reg <= 4'd0;
         minutes_reg  <= 4'd0;
         count_reg    <= 2'd0;
         loadn_reg    <= 1'b1;
         err_reg      <= 1'b0;
      end else begin
         err_reg   <= press && multi;
         loadn_reg <= 1'b1;
         case (state_reg)
            IDLE, ENTRY: begin
               if (single) begin
                  if (cur[11]) begin
                     if (state_reg == ENTRY) begin
                        if (sec_tens_reg > MAX_TENS) begin
                           err_reg <= 1'b1;
                        end else begin
                           state_reg <= LOAD;
                           loadn_reg <= 1'b0;
                        end
                     end
                  end else if (cur[10]) begin
                     sec_ones_reg <= 4'd0;
                     sec_tens_reg <= 4'd0;
                     minutes_reg  <= 4'd0;
                     count_reg    <= 2'd0;
                     state_reg    <= IDLE;
                  end else if (count_reg != 2'd3) begin
                     minutes_reg  <= sec_tens_reg;
                     sec_tens_reg <= sec_ones_reg;
                     sec_ones_reg <= digit;
                     count_reg    <= count_reg + 2'd1;
                     state_reg    <= ENTRY;
                  end
               end
            end
            LOAD: state_reg <= RUN;
            RUN: begin
               // busy is first sampled here one cycle after LOAD, giving RUN its minimum cycle
               if (!bus.busy) begin
                  sec_ones_reg <= 4'd0;
                  sec_tens_reg <= 4'd0;
                  minutes_reg  <= 4'd0;
                  count_reg    <= 2'd0;
                  state_reg    <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.sec_ones = sec_ones_reg;
   assign bus.sec_tens = sec_tens_reg;
   assign bus.minutes  = minutes_reg;
   assign bus.count    = count_reg;
   assign bus.loadn    = loadn_reg;
   assign bus.err      = err_reg;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry: entry, validation, run/exit and reset behaviour.
module tb_time_entry;

`ifdef TIME_ENTRY_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam logic [11:0] START = 12'h800;
   localparam logic [11:0] CLR   = 12'h400;

   logic clk = 1'b0;
   logic clrn;
   int   n_checks = 0;
   int   n_errs = 0;
   int   err_cnt = 0;
   int   lo_cnt = 0;
   int   e0, l0;

   time_entry_if bus ();

   time_entry #(.MAX_SEC_TENS(5)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // pulse counters sample the previous cycle's outputs at each rising edge
   always @(posedge clk) begin
      if (bus.err === 1'b1) err_cnt++;
      if (bus.loadn === 1'b0) lo_cnt++;
   end

   function automatic logic [11:0] kd(input int n);
      return 12'd1 << n;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tap(input logic [11:0] v, input int hold);
      {bus.start_key, bus.clr_key, bus.key} = v;
      repeat (hold) @(negedge clk);
      {bus.start_key, bus.clr_key, bus.key} = '0;
      repeat (LAT + 2) @(negedge clk);
   endtask

   function automatic logic [15:0] digits();
      return {4'd0, bus.minutes, bus.sec_tens, bus.sec_ones};
   endfunction

   initial begin
      clrn = 1'b0;
      bus.key = '0; bus.clr_key = 1'b0; bus.start_key = 1'b0; bus.busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_digits", digits(), 16'h000);
      check("rst_count", 16'(bus.count), 16'd0);
      check("rst_loadn", 16'(bus.loadn), 16'd1);
      check("rst_err", 16'(bus.err), 16'd0);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // 1, 3, 0 then start; first press also checks latency
      bus.key = kd(1);
      repeat (LAT - 1) @(negedge clk);
      check("lat_before", 16'(bus.count), 16'd0);
      @(negedge clk);
      check("lat_after", 16'(bus.count), 16'd1);
      bus.key = '0;
      repeat (LAT + 2) @(negedge clk);
      tap(kd(3), 1);
      tap(kd(0), 1);
      check("130_digits", digits(), 16'h130);
      check("130_count", 16'(bus.count), 16'd3);
      bus.busy = 1'b1;
      l0 = lo_cnt; e0 = err_cnt;
      tap(START, 1);
      check("130_loadn_cycles", 16'(lo_cnt - l0), 16'd1);
      check("130_no_err", 16'(err_cnt - e0), 16'd0);
      check("130_loaded", digits(), 16'h130);
      // RUN ignores digits, start and clear
      tap(kd(7), 1);
      tap(START, 1);
      tap(CLR, 1);
      check("run_hold_digits", digits(), 16'h130);
      check("run_hold_count", 16'(bus.count), 16'd3);
      check("run_no_reload", 16'(lo_cnt - l0), 16'd1);
      bus.busy = 1'b0;
      @(negedge clk);
      check("run_exit_digits", digits(), 16'h000);
      check("run_exit_count", 16'(bus.count), 16'd0);
      repeat (2) @(negedge clk);

      // start with count==0 is ignored
      l0 = lo_cnt; e0 = err_cnt;
      tap(START, 1);
      check("idle_start_loadn", 16'(lo_cnt - l0), 16'd0);
      check("idle_start_err", 16'(err_cnt - e0), 16'd0);

      // 9, 0, start: tens 9 exceeds limit
      tap(kd(9), 1);
      tap(kd(0), 1);
      l0 = lo_cnt; e0 = err_cnt;
      tap(START, 1);
      check("bad_tens_err", 16'(err_cnt - e0), 16'd1);
      check("bad_tens_loadn", 16'(lo_cnt - l0), 16'd0);
      check("bad_tens_digits", digits(), 16'h090);
      tap(CLR, 1);
      check("clr_digits", digits(), 16'h000);

      // 1,2,3,4: fourth ignored silently
      e0 = err_cnt;
      tap(kd(1), 1);
      tap(kd(2), 1);
      tap(kd(3), 1);
      tap(kd(4), 1);
      check("full_digits", digits(), 16'h123);
      check("full_count", 16'(bus.count), 16'd3);
      check("full_no_err", 16'(err_cnt - e0), 16'd0);
      tap(CLR, 1);
      check("clr2_digits", digits(), 16'h000);
      check("clr2_count", 16'(bus.count), 16'd0);

      // simultaneous keys 0 and 2, then held key 5
      tap(kd(2), 1);
      e0 = err_cnt;
      tap(12'h005, 1);
      check("multi_err", 16'(err_cnt - e0), 16'd1);
      check("multi_digits", digits(), 16'h002);
      tap(kd(5), 10);
      check("held_digits", digits(), 16'h025);
      check("held_count", 16'(bus.count), 16'd2);
      tap(CLR, 1);

      // tens exactly at the limit loads
      tap(kd(5), 1);
      tap(kd(9), 1);
      bus.busy = 1'b1;
      l0 = lo_cnt; e0 = err_cnt;
      tap(START, 1);
      check("edge_tens_loadn", 16'(lo_cnt - l0), 16'd1);
      check("edge_tens_err", 16'(err_cnt - e0), 16'd0);
      bus.busy = 1'b0;
      repeat (2) @(negedge clk);
      check("edge_tens_exit", digits(), 16'h000);

      // reset while in LOAD, with a key held through release
      tap(kd(4), 1);
      bus.busy = 1'b1;
      bus.start_key = 1'b1;
      repeat (LAT) @(negedge clk);
      check("load_loadn_low", 16'(bus.loadn), 16'd0);
      clrn = 1'b0;
      #1;
      check("load_rst_loadn", 16'(bus.loadn), 16'd1);
      check("load_rst_digits", digits(), 16'h000);
      check("load_rst_count", 16'(bus.count), 16'd0);
      bus.start_key = 1'b0;
      bus.key = kd(8);
      bus.busy = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      check("held_thru_rst", 16'(bus.count), 16'd0);
      bus.key = '0;
      repeat (LAT + 2) @(negedge clk);
      tap(kd(8), 1);
      check("post_rst_press", digits(), 16'h008);
      check("post_rst_count", 16'(bus.count), 16'd1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter: MAX_SEC_TENS, default 5, highest legal seconds-tens digit accepted at start.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clrn  input  1  asynchronous, active-low reset.
REQ-004 key  input  10  keypad digits 0-9, one bit per digit, active-high level.
REQ-005 clr_key  input  1  clear-entry button, active-high level.
REQ-006 start_key  input  1  start button, active-high level.
REQ-007 busy  input  1  high while the downstream timer digits are counting down.
REQ-008 sec_ones  output  4  BCD seconds-ones data to the timer digits.
REQ-009 sec_tens  output  4  BCD seconds-tens data to the timer digits.
REQ-010 minutes  output  4  BCD minutes data to the timer digits.
REQ-011 loadn  output  1  active-low load strobe to all timer digits, one cycle wide.
REQ-012 count  output  2  number of digits entered, 0-3.
REQ-013 err  output  1  one-cycle error pulse.

Function
REQ-014 A press SHALL be the cycle in which the key/clr_key/start_key vector goes from all-zero to non-zero (edge detect); held inputs SHALL NOT repeat.
REQ-015 A press with more than one bit set across key, clr_key and start_key SHALL be discarded and SHALL pulse err for one cycle.
REQ-016 FSM states: IDLE, ENTRY, LOAD, RUN; reset state IDLE.
REQ-017 IDLE/ENTRY, digit press with count<3: minutes<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit, count<=count+1, state ENTRY; registered, visible the cycle after the press.
REQ-018 Digit press with count==3 SHALL be ignored without err.
REQ-019 clr_key press in IDLE/ENTRY SHALL zero all digits and count, state IDLE.
REQ-020 start_key press in IDLE (count==0) SHALL be ignored.
REQ-021 start_key press in ENTRY with sec_tens>MAX_SEC_TENS SHALL pulse err, keep digits, stay ENTRY.
REQ-022 Otherwise start_key in ENTRY SHALL go to LOAD; in LOAD, loadn=0 for exactly one cycle with digits stable, then RUN.
REQ-023 RUN: all presses except clr_key ignored; clr_key in RUN has no effect on the FSM (abort is owned by the controller).
REQ-024 RUN exits to IDLE, digits and count zeroed, on the cycle after busy is sampled low; busy low on RUN entry SHALL still hold RUN one cycle minimum.
REQ-025 Digit outputs SHALL always hold valid BCD (0-9); key encoding SHALL map bit n to value n.
REQ-026 loadn SHALL be 1 in every state except LOAD.

Reset
REQ-027 clrn low SHALL asynchronously force IDLE, sec_ones=sec_tens=minutes=0, count=0, loadn=1, err=0, edge-detect history=0.
REQ-028 Reset during LOAD SHALL suppress loadn immediately (loadn=1 while clrn low).
REQ-029 A key held through clrn release SHALL NOT register as a press.

Configuration
REQ-030 Macro TIME_ENTRY_SYNC_EN: defined -> key, clr_key, start_key pass a two-flop synchronizer before edge detection, press-to-update latency 3 cycles; undefined -> single register edge detect, latency 1 cycle.
REQ-031 Both builds SHALL reset synchronizer/history flops to 0 and behave identically apart from latency.

Verification
REQ-032 Press 1, 3, 0 then start (no sync build) -> minutes=1, sec_tens=3, sec_ones=0, count=3; loadn low exactly one cycle; state RUN.
REQ-033 Press 9, 0, then start -> sec_tens=9 > 5: err one cycle, loadn stays 1, digits unchanged.
REQ-034 Press 1,2,3,4 -> fourth ignored, digits 1/2/3, no err; clr_key -> all 0, count 0.
REQ-035 key=0000000101 simultaneous -> err pulse, digits unchanged; held key 5 for 10 cycles -> single shift.
REQ-036 In RUN, press 7 and start -> no change; drop busy -> IDLE next cycle, digits 0.
REQ-037 Assert clrn during LOAD -> loadn=1 immediately, all outputs reset; repeat REQ-032 with TIME_ENTRY_SYNC_EN -> identical values, 2 extra cycles latency.
